// File: rtl/spi_mon_pkg.sv
// Shared constants, FSM encoding and frame-record width helpers for the SPI monitor.
package spi_mon_pkg;

  localparam logic SPI_MODE_RISE = 1'b0;
  localparam logic SPI_MODE_FALL = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } spi_state_e;

  function automatic int nbits_w(input int max_bits);
    return $clog2(max_bits + 1);
  endfunction

  function automatic int rec_w(input int max_bits);
    return 2 * max_bits + nbits_w(max_bits) + 1;
  endfunction

endpackage

// File: rtl/spi_cap_fifo.sv
// Show-ahead frame FIFO; write visible at the head one cycle after the push.
// A push while full is refused unless a pop happens in the same cycle.
module spi_cap_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_vld_i,
  input  logic [W-1:0] wr_dat_i,
  input  logic         rd_rdy_i,
  output logic [W-1:0] rd_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == (AW+1)'(DEPTH));
  assign do_rd    = rd_rdy_i & ~empty_o;
  assign do_wr    = wr_vld_i & (~full_o | do_rd);
  assign rd_dat_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/spi_frame_capture.sv
// Passive SPI monitor: captures CS-delimited frames into a show-ahead FIFO.
// Head valid SYNC_STAGES+2 cycles after CS deassert; frames arriving while full are counted as drops.
module spi_frame_capture
  import spi_mon_pkg::*;
#(
  parameter int MAX_BITS    = 32,
  parameter int SYNC_STAGES = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int DROP_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            spi_clk,
  input  logic                            spi_cs,
  input  logic                            spi_do,
  input  logic                            spi_di,
  input  logic                            samp_falling,
  output logic                            cap_valid,
  input  logic                            cap_ready,
  output logic [MAX_BITS-1:0]             cap_do,
  output logic [MAX_BITS-1:0]             cap_di,
  output logic [$clog2(MAX_BITS+1)-1:0]   cap_nbits,
  output logic                            cap_trunc,
  output logic [DROP_W-1:0]               drop_cnt
);

  localparam int NBW  = nbits_w(MAX_BITS);
  localparam int RECW = rec_w(MAX_BITS);

  typedef struct packed {
    logic [MAX_BITS-1:0] f_do;
    logic [MAX_BITS-1:0] f_di;
    logic [NBW-1:0]      nbits;
    logic                trunc;
  } frame_t;

  logic [SYNC_STAGES-1:0] clk_sq, cs_sq, do_sq, di_sq;
  logic                   clk_dq, cs_dq;
  logic                   clk_s, cs_s, do_s, di_s;
  logic                   cs_fall, cs_rise, clk_edge;

  spi_state_e          state_q, state_d;
  logic                mode_q, mode_d;
  logic [MAX_BITS-1:0] do_sr_q, do_sr_d, di_sr_q, di_sr_d;
  logic [NBW-1:0]      cnt_q, cnt_d;
  logic                trunc_q, trunc_d;
  logic                push_q, push_d;
  frame_t              rec_q, rec_d;
  frame_t              head;
  logic [DROP_W-1:0]   drop_q;
  logic                fifo_full, fifo_empty, pop;

  // The extra delayed copy of clk/cs feeds the edge detectors; data uses the same stage as clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sq <= '0;
      cs_sq  <= '0;
      do_sq  <= '0;
      di_sq  <= '0;
      clk_dq <= 1'b0;
      cs_dq  <= 1'b0;
    end else begin
      clk_sq <= {clk_sq[SYNC_STAGES-2:0], spi_clk};
      cs_sq  <= {cs_sq[SYNC_STAGES-2:0], spi_cs};
      do_sq  <= {do_sq[SYNC_STAGES-2:0], spi_do};
      di_sq  <= {di_sq[SYNC_STAGES-2:0], spi_di};
      clk_dq <= clk_sq[SYNC_STAGES-1];
      cs_dq  <= cs_sq[SYNC_STAGES-1];
    end
  end

  assign clk_s    = clk_sq[SYNC_STAGES-1];
  assign cs_s     = cs_sq[SYNC_STAGES-1];
  assign do_s     = do_sq[SYNC_STAGES-1];
  assign di_s     = di_sq[SYNC_STAGES-1];
  assign cs_fall  = cs_dq & ~cs_s;
  assign cs_rise  = ~cs_dq & cs_s;
  assign clk_edge = (mode_q == SPI_MODE_FALL) ? (clk_dq & ~clk_s) : (~clk_dq & clk_s);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    do_sr_d = do_sr_q;
    di_sr_d = di_sr_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    push_d  = 1'b0;
    rec_d   = rec_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_FRAME;
          mode_d  = samp_falling ? SPI_MODE_FALL : SPI_MODE_RISE;
          do_sr_d = '0;
          di_sr_d = '0;
          cnt_d   = '0;
          trunc_d = 1'b0;
        end
      end
      ST_FRAME: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          if (cnt_q != '0) begin
            push_d      = 1'b1;
            rec_d.f_do  = do_sr_q;
            rec_d.f_di  = di_sr_q;
            rec_d.nbits = cnt_q;
            rec_d.trunc = trunc_q;
          end
        end else if (clk_edge && !cs_s) begin
          do_sr_d = {do_sr_q[MAX_BITS-2:0], do_s};
          di_sr_d = {di_sr_q[MAX_BITS-2:0], di_s};
          if (cnt_q == NBW'(MAX_BITS)) trunc_d = 1'b1;
          else                         cnt_d   = cnt_q + NBW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= SPI_MODE_RISE;
      do_sr_q <= '0;
      di_sr_q <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
      push_q  <= 1'b0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      do_sr_q <= do_sr_d;
      di_sr_q <= di_sr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
      push_q  <= push_d;
      rec_q   <= rec_d;
    end
  end

  assign pop = cap_valid & cap_ready;

  spi_cap_fifo #(
    .W     (RECW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (rst),
    .wr_vld_i (push_q),
    .wr_dat_i (rec_q),
    .rd_rdy_i (pop),
    .rd_dat_o (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (push_q && fifo_full && !pop && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign cap_valid = ~fifo_empty;
  assign cap_do    = head.f_do;
  assign cap_di    = head.f_di;
  assign cap_nbits = head.nbits;
  assign cap_trunc = head.trunc;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_spi_frame_capture.sv
// Directed bench for spi_frame_capture: table of frames plus backpressure, CS-pulse and reset sequences.
module tb_spi_frame_capture;

  localparam int MAX_BITS    = 32;
  localparam int SYNC_STAGES = 3;
  localparam int FIFO_DEPTH  = 4;
  localparam int DROP_W      = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                spi_clk, spi_cs, spi_do, spi_di, samp_falling;
  logic                cap_valid, cap_ready;
  logic [MAX_BITS-1:0] cap_do, cap_di;
  logic [5:0]          cap_nbits;
  logic                cap_trunc;
  logic [DROP_W-1:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  spi_frame_capture #(
    .MAX_BITS    (MAX_BITS),
    .SYNC_STAGES (SYNC_STAGES),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DROP_W      (DROP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_clk      (spi_clk),
    .spi_cs       (spi_cs),
    .spi_do       (spi_do),
    .spi_di       (spi_di),
    .samp_falling (samp_falling),
    .cap_valid    (cap_valid),
    .cap_ready    (cap_ready),
    .cap_do       (cap_do),
    .cap_di       (cap_di),
    .cap_nbits    (cap_nbits),
    .cap_trunc    (cap_trunc),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mode;
    int          n;
    logic [63:0] dob;
    logic [63:0] dib;
    logic [31:0] edo;
    logic [31:0] edi;
    int          enb;
    bit          etr;
  } vec_t;

  vec_t tv [4];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Data is valid only around the edge the selected mode samples; the other edge sees the complement.
  task automatic send_bit(input bit mode, input bit bdo, input bit bdi);
    spi_do = mode ? ~bdo : bdo;
    spi_di = mode ? ~bdi : bdi;
    tick(4);
    spi_clk = 1'b1;
    tick(4);
    spi_do = mode ? bdo : ~bdo;
    spi_di = mode ? bdi : ~bdi;
    tick(4);
    spi_clk = 1'b0;
    tick(4);
  endtask

  task automatic send_frame(input bit mode, input int n, input logic [63:0] dob,
                            input logic [63:0] dib, input bit flip, output int lat);
    samp_falling = mode;
    tick(2);
    spi_cs = 1'b0;
    tick(8);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(mode, dob[i], dib[i]);
      if (flip && i == n - 3) samp_falling = ~mode;
    end
    tick(4);
    spi_cs = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (cap_valid && lat == 0) lat = k;
    end
    samp_falling = mode;
  endtask

  task automatic expect_pop(input string name, input logic [31:0] edo, input logic [31:0] edi,
                            input int enb, input bit etr);
    int k;
    k = 0;
    while (!cap_valid && k < 60) begin
      tick(1);
      k++;
    end
    chk($sformatf("%s_vld", name), cap_valid, 1);
    chk($sformatf("%s_do", name), cap_do, edo);
    chk($sformatf("%s_di", name), cap_di, edi);
    chk($sformatf("%s_nbits", name), cap_nbits, enb);
    chk($sformatf("%s_trunc", name), cap_trunc, etr);
    cap_ready = 1'b1;
    tick(1);
    cap_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] b;

    tv[0] = '{1'b0, 32, 64'hA5A5_1234, 64'h0F0F_F0F0, 32'hA5A5_1234, 32'h0F0F_F0F0, 32, 1'b0};
    tv[1] = '{1'b1, 12, 64'hABC, 64'h5A3, 32'h0000_0ABC, 32'h0000_05A3, 12, 1'b0};
    tv[2] = '{1'b0, 40, 64'h12_3456_789A, 64'hFF_00FF_00FF, 32'h3456_789A, 32'h00FF_00FF, 32, 1'b1};
    tv[3] = '{1'b1, 1, 64'h1, 64'h0, 32'h1, 32'h0, 1, 1'b0};

    rst = 1'b0;
    spi_clk = 1'b0;
    spi_cs = 1'b1;
    spi_do = 1'b0;
    spi_di = 1'b0;
    samp_falling = 1'b0;
    cap_ready = 1'b0;
    tick(3);
    chk("rst_valid", cap_valid, 0);
    chk("rst_do", cap_do, 0);
    chk("rst_di", cap_di, 0);
    chk("rst_nbits", cap_nbits, 0);
    chk("rst_trunc", cap_trunc, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b1;
    tick(5);

    for (int i = 0; i < 4; i++) begin
      send_frame(tv[i].mode, tv[i].n, tv[i].dob, tv[i].dib, 1'b1, lat);
      if (i == 0) chk("latency", lat, SYNC_STAGES + 2);
      expect_pop($sformatf("vec%0d", i), tv[i].edo, tv[i].edi, tv[i].enb, tv[i].etr);
    end
    tick(5);
    chk("drained_valid", cap_valid, 0);
    chk("drop_none", drop_cnt, 0);

    for (int f = 0; f < 6; f++) begin
      b = 8'h11 * 8'(f + 1);
      send_frame(1'b0, 8, {56'h0, b}, {56'h0, ~b}, 1'b0, lat);
    end
    chk("bp_drop", drop_cnt, 2);
    tick(10);
    chk("bp_hold_do", cap_do, 32'h11);
    chk("bp_hold_vld", cap_valid, 1);
    for (int f = 0; f < 4; f++) begin
      b = 8'h11 * 8'(f + 1);
      expect_pop($sformatf("bp%0d", f), {24'h0, b}, {24'h0, ~b}, 8, 1'b0);
    end
    tick(5);
    chk("bp_empty", cap_valid, 0);

    spi_cs = 1'b0;
    tick(10);
    spi_cs = 1'b1;
    tick(20);
    chk("cspulse_valid", cap_valid, 0);
    chk("cspulse_drop", drop_cnt, 2);

    samp_falling = 1'b0;
    spi_cs = 1'b0;
    tick(8);
    for (int i = 0; i < 10; i++) send_bit(1'b0, i[0], ~i[0]);
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 1'b0);
    tick(4);
    spi_cs = 1'b1;
    tick(20);
    chk("rstmid_valid", cap_valid, 0);
    chk("rstmid_drop", drop_cnt, 0);
    send_frame(1'b0, 16, 64'hBEEF, 64'h1234, 1'b0, lat);
    expect_pop("beef", 32'h0000_BEEF, 32'h0000_1234, 16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_capture.md
Name: spi_frame_capture

Overview:
Parametrised SPI bus monitor. It passively samples spi_clk, spi_cs, spi_do and spi_di in the clk domain and captures frames of any length up to MAX_BITS. The SPI mode (sample edge) is selectable per frame. Completed frames are queued in a FIFO with a valid/ready handshake toward the host/UART formatter, with truncation and drop accounting.

Parameters:
MAX_BITS, 32, capture shift-register width and maximum bit count reported
SYNC_STAGES, 3, synchroniser depth for SPI inputs (min 2)
FIFO_DEPTH, 4, frame FIFO entries (power of 2, min 2)
DROP_W, 16, width of dropped-frame counter

Ports:
clk  in  1  system clock, rising edge; must be at least 4x spi_clk
rst  in  1  asynchronous, active-low reset (0 = reset)
spi_clk  in  1  monitored SPI clock, asynchronous
spi_cs  in  1  monitored chip select, active low, asynchronous
spi_do  in  1  monitored controller-out data
spi_di  in  1  monitored controller-in data
samp_falling  in  1  0 = sample on spi_clk rise, 1 = on fall; latched at frame start
cap_valid  out  1  FIFO head holds a frame
cap_ready  in  1  consumer accepts head when cap_valid=1
cap_do  out  MAX_BITS  captured spi_do bits of head frame
cap_di  out  MAX_BITS  captured spi_di bits of head frame
cap_nbits  out  $clog2(MAX_BITS+1)  bit count of head frame, saturates at MAX_BITS
cap_trunc  out  1  head frame had more than MAX_BITS edges
drop_cnt  out  DROP_W  frames lost to FIFO full, saturating

Behaviour:
- Reset (rst=0, async): all outputs 0; sync chains for spi_clk/do/di = 0; spi_cs chain = 0; FSM IDLE; FIFO empty; latched mode = 0.
- Synchronisers: SYNC_STAGES flops per input. Edge detect compares stage SYNC_STAGES-1 (s) with stage SYNC_STAGES (s_d).
- cs_fall = s_d&~s; cs_rise = ~s_d&s; clk_edge = rising or falling per latched mode.
- FSM IDLE: on cs_fall -> FRAME; clear shift regs and bit count; clear trunc; latch samp_falling. clk edges are ignored in IDLE.
- FSM FRAME: on clk_edge with synced cs low, shift left: sr <= {sr[MAX_BITS-2:0], data_sync}. Data is sampled from the same sync stage as the clk edge. Bit count +1, saturating at MAX_BITS. An edge while count==MAX_BITS sets trunc; the retained bits are the last MAX_BITS.
- Frames shorter than MAX_BITS: the first bit is at position nbits-1; upper bits are 0.
- FRAME on cs_rise -> IDLE. If nbits>0, push {do,di,nbits,trunc}. If nbits==0 (CS pulse with no clocks), no push.
- Same-cycle cs_rise and clk_edge: the clk edge is ignored (CS deasserted).
- Reset released with CS low: the cs chain reset value of 0 prevents a false cs_fall, so the partial frame is never captured. Capture starts at the next real falling edge.
- FIFO: show-ahead. Push at cycle T gives cap_valid=1 at T+1 if the FIFO was empty. Total latency from a pin edge on spi_cs is SYNC_STAGES+2 clk cycles.
- Pop when cap_valid&cap_ready. Outputs hold stable while cap_valid&~cap_ready.
- Full: a push with no simultaneous pop drops the frame and increments drop_cnt, saturating at all-ones. Push and pop in the same cycle while full: both occur, no drop.
- Push and pop in the same cycle while non-empty: occupancy unchanged.
- samp_falling changes mid-frame have no effect until the next cs_fall.

Decomposition:
- Package spi_mon_pkg: SPI_MODE_RISE/FALL constants; FSM state encoding (IDLE, FRAME); frame record field widths as functions of MAX_BITS.
- Sub-module spi_cap_fifo: parametrised synchronous show-ahead FIFO. Width 2*MAX_BITS+$clog2(MAX_BITS+1)+1, depth FIFO_DEPTH. Outputs full/empty. Async active-low reset.
- Top holds synchronisers, edge detect, FSM, shift regs and drop counter.

Test Plan:
- Mode rise, 32 clocks, do=0xA5A5_1234, di=0x0F0F_F0F0 -> cap_do=0xA5A51234, cap_di=0x0F0FF0F0, nbits=32, trunc=0, cap_valid SYNC_STAGES+2 cycles after CS rise.
- Mode fall, 12 clocks, do=0xABC -> cap_do=0x0000_0ABC, nbits=12, trunc=0.
- 40 clocks, do bits = 0x12_3456_789A (MSB first) -> cap_do=0x3456789A, nbits=32, trunc=1.
- cap_ready=0, send 6 frames of 8 bits, FIFO_DEPTH=4 -> 4 frames held in order, drop_cnt=2; then cap_ready=1 drains all 4 with values intact.
- CS pulse low 10 cycles with no spi_clk -> no cap_valid, drop_cnt unchanged.
- Assert rst mid-frame after 10 clocks, release with CS still low -> no frame emitted. The next full 16-bit frame 0xBEEF is captured correctly.
